// File: rtl/ysyx_pkg.sv
// Shared ROB sizing and the per-entry lifecycle state.
package ysyx_pkg;
  localparam int ROB_SIZE = 4;
  localparam int XLEN     = 32;
  localparam int TW       = $clog2(ROB_SIZE) + 1;

  typedef enum logic [1:0] {ROB_FREE, ROB_BUSY, ROB_DONE} rob_state_t;
endpackage

// File: rtl/ysyx_rob_fwd.sv
// One operand-lookup port: returns a DONE entry's result, or bypasses a
// writeback that names the same tag in this cycle.
module ysyx_rob_fwd #(
  parameter int N    = 4,
  parameter int XLEN = 32,
  parameter int TW   = $clog2(N) + 1
) (
  input  logic [TW-1:0]                tag,
  input  ysyx_pkg::rob_state_t [N-1:0] state,
  input  logic [N-1:0][XLEN-1:0]       result,
  input  logic                         wb_valid,
  input  logic [TW-1:0]                wb_dest,
  input  logic [XLEN-1:0]              wb_result,
  output logic                         hit,
  output logic [XLEN-1:0]              val
);
  import ysyx_pkg::*;
  localparam int PW = $clog2(N);
  localparam logic [TW-1:0] NT = TW'(N);

  logic [PW-1:0] idx;
  assign idx = PW'(tag - TW'(1));

  always_comb begin
    hit = 1'b0;
    val = '0;
    // Stored result wins over a writeback aimed at an already-DONE entry.
    if (tag != '0 && tag <= NT) begin
      if (state[idx] == ROB_DONE) begin
        hit = 1'b1;
        val = result[idx];
      end else if (wb_valid && wb_dest == tag) begin
        hit = 1'b1;
        val = wb_result;
      end
    end
  end
endmodule

// File: rtl/ysyx_rob.sv
// Reorder buffer: in-order commit of out-of-order EXU results, mispredict flush
// raised at commit, and operand forwarding for IDU source-tag lookups.
module ysyx_rob #(
  parameter int ROB_SIZE = ysyx_pkg::ROB_SIZE,
  parameter int XLEN     = ysyx_pkg::XLEN,
  parameter int TW       = $clog2(ROB_SIZE) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [4:0]      disp_rd,
  input  logic [XLEN-1:0] disp_pc,
  input  logic [XLEN-1:0] disp_pnpc,
  output logic [TW-1:0]   disp_tag,
  input  logic [TW-1:0]   q1_tag,
  input  logic [TW-1:0]   q2_tag,
  output logic            q1_hit,
  output logic            q2_hit,
  output logic [XLEN-1:0] q1_val,
  output logic [XLEN-1:0] q2_val,
  input  logic            wb_valid,
  input  logic [TW-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_result,
  input  logic [XLEN-1:0] wb_npc,
  output logic            cmt_valid,
  output logic [4:0]      cmt_rd,
  output logic [XLEN-1:0] cmt_data,
  output logic [XLEN-1:0] cmt_pc,
  output logic [TW-1:0]   cmt_tag,
  output logic            flush,
  output logic [XLEN-1:0] flush_pc
);
  import ysyx_pkg::*;
  localparam int PW = $clog2(ROB_SIZE);
  localparam logic [TW-1:0] SIZE_T = TW'(ROB_SIZE);

  rob_state_t [ROB_SIZE-1:0]       state;
  logic [ROB_SIZE-1:0][4:0]        rd_q;
  logic [ROB_SIZE-1:0][XLEN-1:0]   pc_q, pnpc_q, res_q, npc_q;
  logic [TW-1:0]                   head, tail;
  logic                            flush_q;
  logic [XLEN-1:0]                 flush_pc_q;

  logic [PW-1:0] hidx, tidx, widx;
  logic          full, alloc, commit, wb_ok, mispred;

  assign hidx    = head[PW-1:0];
  assign tidx    = tail[PW-1:0];
  assign widx    = PW'(wb_dest - TW'(1));
  // Pointers carry a wrap bit, so equal indices with differing MSBs means full.
  assign full    = (head ^ tail) == SIZE_T;
  assign alloc   = disp_valid && disp_ready;
  assign commit  = state[hidx] == ROB_DONE && !flush_q && !reset;
  assign wb_ok   = wb_valid && !flush_q && wb_dest != '0 && wb_dest <= SIZE_T &&
                   state[widx] == ROB_BUSY;
  assign mispred = commit && npc_q[hidx] != pnpc_q[hidx];

  assign disp_ready = !full && !flush_q && !reset;
  assign disp_tag   = reset ? '0 : TW'(tidx) + TW'(1);
  assign cmt_valid  = commit;
  assign cmt_rd     = commit ? rd_q[hidx]  : '0;
  assign cmt_data   = commit ? res_q[hidx] : '0;
  assign cmt_pc     = commit ? pc_q[hidx]  : '0;
  assign cmt_tag    = commit ? TW'(hidx) + TW'(1) : '0;
  assign flush      = flush_q && !reset;
  assign flush_pc   = flush ? flush_pc_q : '0;

  logic [1:0][TW-1:0]   q_tag;
  logic [1:0]           q_hit;
  logic [1:0][XLEN-1:0] q_val;
  assign q_tag = {q2_tag, q1_tag};

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    ysyx_rob_fwd #(.N(ROB_SIZE), .XLEN(XLEN), .TW(TW)) u_fwd (
      .tag       (q_tag[p]),
      .state     (state),
      .result    (res_q),
      .wb_valid  (wb_valid),
      .wb_dest   (wb_dest),
      .wb_result (wb_result),
      .hit       (q_hit[p]),
      .val       (q_val[p])
    );
  end

  assign q1_hit = q_hit[0] && !reset;
  assign q2_hit = q_hit[1] && !reset;
  assign q1_val = reset ? '0 : q_val[0];
  assign q2_val = reset ? '0 : q_val[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) state[i] <= ROB_FREE;
    end else if (flush_q) begin
      head    <= '0;
      tail    <= '0;
      flush_q <= 1'b0;
      for (int i = 0; i < ROB_SIZE; i++) state[i] <= ROB_FREE;
    end else begin
      flush_q <= mispred;
      if (mispred) flush_pc_q <= npc_q[hidx];
      // commit/writeback/alloc always hit distinct slots (DONE/BUSY/FREE).
      if (commit) begin
        state[hidx] <= ROB_FREE;
        head        <= head + TW'(1);
      end
      if (wb_ok) begin
        state[widx] <= ROB_DONE;
        res_q[widx] <= wb_result;
        npc_q[widx] <= wb_npc;
      end
      if (alloc) begin
        state[tidx]  <= ROB_BUSY;
        rd_q[tidx]   <= disp_rd;
        pc_q[tidx]   <= disp_pc;
        pnpc_q[tidx] <= disp_pnpc;
        tail         <= tail + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ysyx_rob.sv
// Self-checking bench for ysyx_rob: directed scenarios plus a randomized run
// against a program-order queue model.
module tb_ysyx_rob;
  localparam int N = 4;

  logic        clock = 1'b0, reset = 1'b1;
  logic        disp_valid = 1'b0, disp_ready;
  logic [4:0]  disp_rd = '0;
  logic [31:0] disp_pc = '0, disp_pnpc = '0;
  logic [2:0]  disp_tag, q1_tag = '0, q2_tag = '0;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_val, q2_val;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_dest = '0;
  logic [31:0] wb_result = '0, wb_npc = '0;
  logic        cmt_valid;
  logic [4:0]  cmt_rd;
  logic [31:0] cmt_data, cmt_pc;
  logic [2:0]  cmt_tag;
  logic        flush;
  logic [31:0] flush_pc;

  int n_cmp = 0, n_err = 0;

  ysyx_rob dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
    .disp_pc(disp_pc), .disp_pnpc(disp_pnpc), .disp_tag(disp_tag),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_val(q1_val), .q2_val(q2_val),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_npc(wb_npc),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_data(cmt_data), .cmt_pc(cmt_pc),
    .cmt_tag(cmt_tag), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clock = ~clock;

  // Reference model: live instructions in program order.
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [31:0] pc, pnpc, res, npc;
    bit          done;
  } ent_t;
  ent_t        mq[$];
  int          alloc_cnt = 0;
  bit          m_flush = 0;
  logic [31:0] m_flush_pc = '0;

  function automatic void model_lookup(input logic [2:0] tag, output logic hit,
                                       output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (tag == 3'd0 || int'(tag) > N) return;
    foreach (mq[i])
      if (mq[i].tag == int'(tag) && mq[i].done) begin
        hit = 1'b1;
        val = mq[i].res;
        return;
      end
    if (wb_valid && wb_dest == tag) begin
      hit = 1'b1;
      val = wb_result;
    end
  endfunction

  // Advance the model with the current inputs, then step the clock.
  task automatic cycle();
    bit cm, can, fl;
    logic [31:0] fpc;
    ent_t e;
    cm = 0; can = 0; fl = 0; fpc = '0;
    if (reset || m_flush) begin
      mq.delete();
      alloc_cnt = 0;
      m_flush = 0;
    end else begin
      cm  = mq.size() > 0 && mq[0].done;
      can = mq.size() < N;
      if (cm && mq[0].npc !== mq[0].pnpc) begin fl = 1; fpc = mq[0].npc; end
      if (wb_valid)
        foreach (mq[i])
          if (mq[i].tag == int'(wb_dest) && !mq[i].done) begin
            mq[i].done = 1; mq[i].res = wb_result; mq[i].npc = wb_npc;
          end
      if (cm) void'(mq.pop_front());
      if (disp_valid && can) begin
        e.tag = alloc_cnt % N + 1; e.rd = disp_rd; e.pc = disp_pc; e.pnpc = disp_pnpc;
        e.res = '0; e.npc = '0; e.done = 0;
        mq.push_back(e);
        alloc_cnt++;
      end
      m_flush = fl;
      m_flush_pc = fpc;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; wb_valid = 0; wb_dest = '0; wb_result = '0; wb_npc = '0;
    q1_tag = '0; q2_tag = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic dispatch(input int rd, input logic [31:0] pc, input logic [31:0] pnpc);
    disp_valid = 1; disp_rd = 5'(rd); disp_pc = pc; disp_pnpc = pnpc;
  endtask

  task automatic writeback(input int tag, input logic [31:0] res, input logic [31:0] npc);
    wb_valid = 1; wb_dest = 3'(tag); wb_result = res; wb_npc = npc;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; q1_tag = 3'd1; wb_valid = 1; wb_dest = 3'd1; wb_result = 32'h1234;
    cycle();
    @(negedge clock);
    n_cmp++; if (cmt_valid !== 1'b0) begin n_err++; $display("FAIL reset_cmt_valid got %0d exp 0", cmt_valid); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %0d exp 0", flush); end
    n_cmp++; if (q1_hit !== 1'b0 || q1_val !== 32'h0) begin n_err++; $display("FAIL reset_q1 got %0d/%h exp 0/0", q1_hit, q1_val); end
    n_cmp++; if (disp_tag !== 3'd0 || cmt_data !== 32'h0) begin n_err++; $display("FAIL reset_data got tag %0d data %h exp 0/0", disp_tag, cmt_data); end
    reset = 0;
    idle();
    @(negedge clock);
    n_cmp++; if (disp_ready !== 1'b1 || disp_tag !== 3'd1) begin n_err++; $display("FAIL post_reset_disp got rdy %0d tag %0d exp 1/1", disp_ready, disp_tag); end
    cycle();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dispatch(i + 1, 32'h8000_0000 + 32'(4 * i), 32'h8000_0004 + 32'(4 * i));
      @(negedge clock);
      n_cmp++; if (disp_ready !== 1'b1 || disp_tag !== 3'(i + 1)) begin n_err++; $display("FAIL fill_tag%0d got rdy %0d tag %0d exp 1/%0d", i, disp_ready, disp_tag, i + 1); end
      n_cmp++; if (cmt_valid !== 1'b0) begin n_err++; $display("FAIL fill_cmt%0d got %0d exp 0", i, cmt_valid); end
      cycle();
    end
    idle();
    @(negedge clock);
    n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got %0d exp 0", disp_ready); end
    n_cmp++; if (cmt_valid !== 1'b0) begin n_err++; $display("FAIL fill_full_cmt got %0d exp 0", cmt_valid); end
  endtask

  task automatic test_ooo_commit();
    int order[3] = '{3, 1, 2};
    int exp_tag[3] = '{1, 2, 3};
    for (int i = 0; i < 3; i++) begin
      idle();
      writeback(order[i], 32'h1000_0000 + 32'(order[i] * 17), 32'h8000_0000 + 32'(4 * order[i]));
      @(negedge clock);
      n_cmp++; if (cmt_valid !== (i == 2)) begin n_err++; $display("FAIL ooo_wb%0d_cmt got %0d exp %0d", i, cmt_valid, i == 2); end
      if (i == 2) begin
        n_cmp++; if (cmt_tag !== 3'd1 || cmt_data !== 32'h1000_0011 || cmt_rd !== 5'd1) begin n_err++; $display("FAIL ooo_first got tag %0d data %h rd %0d exp 1/10000011/1", cmt_tag, cmt_data, cmt_rd); end
      end
      cycle();
    end
    idle();
    for (int i = 1; i < 3; i++) begin
      @(negedge clock);
      n_cmp++; if (cmt_valid !== 1'b1 || cmt_tag !== 3'(exp_tag[i]) || cmt_data !== 32'h1000_0000 + 32'(exp_tag[i] * 17)) begin n_err++; $display("FAIL ooo_commit%0d got v %0d tag %0d data %h exp 1/%0d", i, cmt_valid, cmt_tag, cmt_data, exp_tag[i]); end
      n_cmp++; if (cmt_pc !== 32'h8000_0000 + 32'(4 * (exp_tag[i] - 1))) begin n_err++; $display("FAIL ooo_pc%0d got %h", i, cmt_pc); end
      cycle();
    end
    @(negedge clock);
    n_cmp++; if (cmt_valid !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL ooo_tail got cmt %0d flush %0d exp 0/0", cmt_valid, flush); end
  endtask

  task automatic test_full_wrap();
    int seq[4] = '{4, 1, 3, 2};
    int exp_tag[4] = '{2, 3, 4, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dispatch(i + 1, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
      cycle();
    end
    idle();
    writeback(1, 32'hAAAA, 32'h104);
    cycle();
    idle();
    dispatch(9, 32'h200, 32'h204);
    @(negedge clock);
    n_cmp++; if (cmt_valid !== 1'b1 || cmt_tag !== 3'd1) begin n_err++; $display("FAIL wrap_commit got v %0d tag %0d exp 1/1", cmt_valid, cmt_tag); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL wrap_no_reuse got %0d exp 0", disp_ready); end
    cycle();
    @(negedge clock);
    n_cmp++; if (disp_ready !== 1'b1 || disp_tag !== 3'd1) begin n_err++; $display("FAIL wrap_alloc got rdy %0d tag %0d exp 1/1", disp_ready, disp_tag); end
    cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      writeback(seq[i], 32'h5000 + 32'(seq[i]), (seq[i] == 1) ? 32'h204 : 32'h104 + 32'(4 * (seq[i] - 1)));
      @(negedge clock);
      n_cmp++; if (cmt_valid !== 1'b0) begin n_err++; $display("FAIL wrap_wait%0d got %0d exp 0", i, cmt_valid); end
      cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++; if (cmt_valid !== 1'b1 || cmt_tag !== 3'(exp_tag[i]) || cmt_data !== 32'h5000 + 32'(exp_tag[i])) begin n_err++; $display("FAIL wrap_drain%0d got v %0d tag %0d data %h exp 1/%0d", i, cmt_valid, cmt_tag, cmt_data, exp_tag[i]); end
      cycle();
    end
    @(negedge clock);
    n_cmp++; if (cmt_pc !== 32'h0 || cmt_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty got v %0d pc %h exp 0/0", cmt_valid, cmt_pc); end
  endtask

  task automatic test_mispredict();
    do_reset();
    dispatch(5, 32'h8000_0000, 32'h8000_0004);
    cycle();
    dispatch(6, 32'h8000_0004, 32'h8000_0008);
    writeback(1, 32'h55, 32'h8000_0100);
    cycle();
    idle();
    @(negedge clock);
    n_cmp++; if (cmt_valid !== 1'b1 || cmt_pc !== 32'h8000_0000 || flush !== 1'b0) begin n_err++; $display("FAIL mp_commit got v %0d pc %h flush %0d exp 1/80000000/0", cmt_valid, cmt_pc, flush); end
    cycle();
    writeback(2, 32'h66, 32'h8000_0008);
    dispatch(7, 32'h9000_0000, 32'h9000_0004);
    @(negedge clock);
    n_cmp++; if (flush !== 1'b1 || flush_pc !== 32'h8000_0100) begin n_err++; $display("FAIL mp_flush got %0d pc %h exp 1/80000100", flush, flush_pc); end
    n_cmp++; if (cmt_valid !== 1'b0 || disp_ready !== 1'b0) begin n_err++; $display("FAIL mp_flush_gate got cmt %0d rdy %0d exp 0/0", cmt_valid, disp_ready); end
    cycle();
    idle();
    q1_tag = 3'd2;
    @(negedge clock);
    n_cmp++; if (flush !== 1'b0 || disp_ready !== 1'b1 || disp_tag !== 3'd1) begin n_err++; $display("FAIL mp_after got flush %0d rdy %0d tag %0d exp 0/1/1", flush, disp_ready, disp_tag); end
    n_cmp++; if (cmt_valid !== 1'b0 || q1_hit !== 1'b0) begin n_err++; $display("FAIL mp_empty got cmt %0d hit %0d exp 0/0", cmt_valid, q1_hit); end
    cycle();
  endtask

  task automatic test_bypass();
    do_reset();
    dispatch(1, 32'h0, 32'h4);
    cycle();
    dispatch(2, 32'h4, 32'h8);
    cycle();
    idle();
    writeback(2, 32'hdeadbeef, 32'h8);
    q1_tag = 3'd2; q2_tag = 3'd0;
    @(negedge clock);
    n_cmp++; if (q1_hit !== 1'b1 || q1_val !== 32'hdeadbeef) begin n_err++; $display("FAIL byp_q1 got %0d/%h exp 1/deadbeef", q1_hit, q1_val); end
    n_cmp++; if (q2_hit !== 1'b0 || q2_val !== 32'h0) begin n_err++; $display("FAIL byp_q2_tag0 got %0d/%h exp 0/0", q2_hit, q2_val); end
    cycle();
    idle();
    q1_tag = 3'd2; q2_tag = 3'd1;
    @(negedge clock);
    n_cmp++; if (q1_hit !== 1'b1 || q1_val !== 32'hdeadbeef) begin n_err++; $display("FAIL byp_done got %0d/%h exp 1/deadbeef", q1_hit, q1_val); end
    n_cmp++; if (q2_hit !== 1'b0 || q2_val !== 32'h0) begin n_err++; $display("FAIL byp_busy got %0d/%h exp 0/0", q2_hit, q2_val); end
    cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dispatch(i + 1, 32'h40 + 32'(4 * i), 32'h44 + 32'(4 * i));
      cycle();
    end
    idle();
    reset = 1;
    cycle();
    reset = 0;
    writeback(1, 32'h77, 32'h44);
    @(negedge clock);
    n_cmp++; if (cmt_valid !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL rstmid_out got cmt %0d flush %0d exp 0/0", cmt_valid, flush); end
    n_cmp++; if (disp_tag !== 3'd1 || disp_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_tail got tag %0d rdy %0d exp 1/1", disp_tag, disp_ready); end
    cycle();
    idle();
    @(negedge clock);
    n_cmp++; if (cmt_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_empty got %0d exp 0", cmt_valid); end
    cycle();
  endtask

  task automatic test_random();
    int cand[$];
    int k;
    logic eh1, eh2;
    logic [31:0] ev1, ev2;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      disp_valid = 1'($urandom_range(0, 1));
      disp_rd    = 5'($urandom);
      disp_pc    = $urandom;
      disp_pnpc  = ($urandom_range(0, 7) == 0) ? $urandom : disp_pc + 32'd4;
      wb_result  = $urandom;
      cand.delete();
      foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = cand[$urandom_range(0, cand.size() - 1)];
        wb_valid = 1;
        wb_dest  = 3'(mq[k].tag);
        wb_npc   = ($urandom_range(0, 5) == 0) ? $urandom : mq[k].pnpc;
      end else if ($urandom_range(0, 3) == 0) begin
        wb_valid = 1;
        wb_dest  = 3'($urandom_range(0, 4));
        wb_npc   = $urandom;
      end
      q1_tag = 3'($urandom_range(0, 7));
      q2_tag = 3'($urandom_range(0, 4));
      @(negedge clock);
      n_cmp++; if (disp_ready !== (!m_flush && mq.size() < N)) begin n_err++; $display("FAIL rnd_ready c%0d got %0d exp %0d", cyc, disp_ready, !m_flush && mq.size() < N); end
      if (!m_flush && mq.size() < N) begin
        n_cmp++; if (disp_tag !== 3'(alloc_cnt % N + 1)) begin n_err++; $display("FAIL rnd_tag c%0d got %0d exp %0d", cyc, disp_tag, alloc_cnt % N + 1); end
      end
      n_cmp++; if (cmt_valid !== (!m_flush && mq.size() > 0 && mq[0].done)) begin n_err++; $display("FAIL rnd_cmt c%0d got %0d", cyc, cmt_valid); end
      if (!m_flush && mq.size() > 0 && mq[0].done) begin
        n_cmp++; if (cmt_tag !== 3'(mq[0].tag) || cmt_data !== mq[0].res || cmt_pc !== mq[0].pc || cmt_rd !== mq[0].rd) begin n_err++; $display("FAIL rnd_cmt_fields c%0d got tag %0d data %h pc %h rd %0d exp %0d/%h/%h/%0d", cyc, cmt_tag, cmt_data, cmt_pc, cmt_rd, mq[0].tag, mq[0].res, mq[0].pc, mq[0].rd); end
      end
      n_cmp++; if (flush !== m_flush) begin n_err++; $display("FAIL rnd_flush c%0d got %0d exp %0d", cyc, flush, m_flush); end
      if (m_flush) begin
        n_cmp++; if (flush_pc !== m_flush_pc) begin n_err++; $display("FAIL rnd_flush_pc c%0d got %h exp %h", cyc, flush_pc, m_flush_pc); end
      end
      model_lookup(q1_tag, eh1, ev1);
      model_lookup(q2_tag, eh2, ev2);
      n_cmp++; if (q1_hit !== eh1 || q1_val !== ev1) begin n_err++; $display("FAIL rnd_q1 c%0d tag %0d got %0d/%h exp %0d/%h", cyc, q1_tag, q1_hit, q1_val, eh1, ev1); end
      n_cmp++; if (q2_hit !== eh2 || q2_val !== ev2) begin n_err++; $display("FAIL rnd_q2 c%0d tag %0d got %0d/%h exp %0d/%h", cyc, q2_tag, q2_hit, q2_val, eh2, ev2); end
      cycle();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_ooo_commit();
    test_full_wrap();
    test_mispredict();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
